// File: rtl/snow64_instr_fetch_unit_if.sv
// Bus bundle between the Snow64 fetch unit, the instruction cache,
// the redirect source and the decode stage.
//   out_icache_req/addr   : read request to the I-cache
//   in_icache_valid/instr : I-cache response (level valid)
//   in_redirect_valid/pc  : single-cycle branch/jump redirect
//   out_instr_valid/instr/pc, in_instr_ready : decode handshake on FIFO head
// master = fetch unit side, slave = environment side.
interface snow64_instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   out_icache_req;
  logic [ADDR_WIDTH-1:0]  out_icache_addr;
  logic                   in_icache_valid;
  logic [INSTR_WIDTH-1:0] in_icache_instr;
  logic                   in_redirect_valid;
  logic [ADDR_WIDTH-1:0]  in_redirect_pc;
  logic                   out_instr_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_instr_pc;
  logic                   in_instr_ready;

  modport master (
    output out_icache_req, out_icache_addr,
    input  in_icache_valid, in_icache_instr,
    input  in_redirect_valid, in_redirect_pc,
    output out_instr_valid, out_instr, out_instr_pc,
    input  in_instr_ready
  );

  modport slave (
    input  out_icache_req, out_icache_addr,
    output in_icache_valid, in_icache_instr,
    output in_redirect_valid, in_redirect_pc,
    input  out_instr_valid, out_instr, out_instr_pc,
    output in_instr_ready
  );
endinterface

// File: rtl/snow64_instr_fetch_unit.sv
// Snow64 instruction fetch unit.
// Holds the fetch PC, issues reads to the I-cache, tracks hit/miss timing of
// each response, and buffers fetched instructions (tagged with their PC) in a
// small FIFO drained by decode. Redirects flush the FIFO and discard any
// in-flight response.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : snow64_instr_fetch_unit_if.master (cache, redirect, decode signals)
module snow64_instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic                        clk,
  input logic                        rst_n,
  snow64_instr_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StResp, StMiss} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                    discard_q, discard_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0]  instr_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem_q    [FIFO_DEPTH];

  logic redirect;
  logic accept;
  logic push;
  logic pop;
  logic issue;

  always_comb begin
    redirect = bus.in_redirect_valid;
    accept   = (state_q != StIdle) && bus.in_icache_valid;
    push     = accept && !discard_q && !redirect;
    pop      = (count_q != '0) && bus.in_instr_ready && !redirect;
    // Room check uses the pre-pop count: a same-cycle pop never frees a slot.
    issue    = !redirect && ((state_q == StIdle) || accept) &&
               ((count_q + CNT_W'(push)) < DEPTH_C);

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      fetch_pc_d = bus.in_redirect_pc & PC_MASK;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      // A response arriving in the redirect cycle is simply dropped; only a
      // response still pending afterwards needs the discard marker.
      if (accept) begin
        state_d   = StIdle;
        discard_d = 1'b0;
      end else if (state_q != StIdle) begin
        state_d   = StMiss;
        discard_d = 1'b1;
      end
    end else begin
      if (accept) begin
        discard_d = 1'b0;
      end
      if (issue) begin
        state_d       = StResp;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end else if (accept) begin
        state_d = StIdle;
      end else if (state_q == StResp) begin
        state_d = StMiss;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= bus.in_icache_instr;
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

  assign bus.out_icache_req  = issue & rst_n;
  assign bus.out_icache_addr = fetch_pc_q;
  assign bus.out_instr_valid = (count_q != '0);
  assign bus.out_instr       = instr_mem_q[rd_ptr_q];
  assign bus.out_instr_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_snow64_instr_fetch_unit.sv
// Self-checking bench for snow64_instr_fetch_unit: a directed per-cycle vector
// table for the hit stream, miss, FIFO-full, redirect and PC-wrap cases, then
// randomized cache/redirect/decode traffic checked against a queue-based model.
module tb_snow64_instr_fetch_unit;

  localparam int unsigned AW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snow64_instr_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  snow64_instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          redir;
    logic [AW-1:0] rpc;
    logic          valid;
    logic [IW-1:0] instr;
    logic          ready;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_ov;
    logic [IW-1:0] exp_instr;
    logic [AW-1:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_mis = 0;

  function automatic vec_t mk(input logic redir, input logic [AW-1:0] rpc,
                              input logic valid, input logic [IW-1:0] instr,
                              input logic ready, input logic exp_req,
                              input logic [AW-1:0] exp_addr, input logic exp_ov,
                              input logic [IW-1:0] exp_instr,
                              input logic [AW-1:0] exp_pc);
    vec_t v;
    v.redir = redir;     v.rpc = rpc;           v.valid = valid;
    v.instr = instr;     v.ready = ready;       v.exp_req = exp_req;
    v.exp_addr = exp_addr; v.exp_ov = exp_ov;   v.exp_instr = exp_instr;
    v.exp_pc = exp_pc;
    return v;
  endfunction

  // Instruction word the directed-test cache returns for a given PC.
  function automatic logic [IW-1:0] hi(input logic [AW-1:0] pc);
    return 32'h1000_0000 + pc[31:0];
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [AW-1:0] rpc,
                       input logic valid, input logic [IW-1:0] instr,
                       input logic ready);
    bus.in_redirect_valid = redir;
    bus.in_redirect_pc    = rpc;
    bus.in_icache_valid   = valid;
    bus.in_icache_instr   = instr;
    bus.in_instr_ready    = ready;
  endtask

  // Asserts reset mid-cycle and checks outputs; rst_n stays low until the
  // next stimulus cycle releases it.
  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    rst_n = 1'b0;
    #1;
    chk({tag, " reset req"},   AW'(bus.out_icache_req), '0);
    chk({tag, " reset addr"},  bus.out_icache_addr, '0);
    chk({tag, " reset ov"},    AW'(bus.out_instr_valid), '0);
    chk({tag, " reset instr"}, AW'(bus.out_instr), '0);
    chk({tag, " reset pc"},    bus.out_instr_pc, '0);
    @(negedge clk);
    #1;
    chk({tag, " reset req held"}, AW'(bus.out_icache_req), '0);
  endtask

  // Random-phase model: pending request, discard flag, FIFO as a queue.
  logic [AW-1:0] m_fpc;
  bit            m_pend;
  bit            m_disc;
  logic [AW-1:0] m_pend_pc;
  logic [IW-1:0] m_pend_instr;
  int            m_lat;
  ent_t          m_q[$];

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    // ---- directed table ----
    for (int k = 0; k <= 8; k++) begin
      tbl.push_back(mk(1'b0, '0, (k >= 1), (k >= 1) ? hi(AW'(4 * (k - 1))) : '0,
                       1'b1, 1'b1, AW'(4 * k), (k >= 2),
                       (k >= 2) ? hi(AW'(4 * (k - 2))) : '0,
                       (k >= 2) ? AW'(4 * (k - 2)) : '0));
    end
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h24, 1'b1, hi(64'h1C), 64'h1C));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h24, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 64'h24, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h24), 1'b0, 1'b1, 64'h28, 1'b1, 32'hDEAD_BEEF, 64'h20));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h28), 1'b0, 1'b1, 64'h2C, 1'b1, 32'hDEAD_BEEF, 64'h20));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h2C), 1'b0, 1'b0, 64'h30, 1'b1, 32'hDEAD_BEEF, 64'h20));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h30, 1'b1, 32'hDEAD_BEEF, 64'h20));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h30, 1'b1, 32'hDEAD_BEEF, 64'h20));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 64'h30, 1'b1, hi(64'h24), 64'h24));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h30), 1'b1, 1'b1, 64'h34, 1'b1, hi(64'h28), 64'h28));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h34), 1'b1, 1'b1, 64'h38, 1'b1, hi(64'h2C), 64'h2C));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h38), 1'b1, 1'b1, 64'h3C, 1'b1, hi(64'h30), 64'h30));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h40, 1'b1, hi(64'h34), 64'h34));
    tbl.push_back(mk(1'b1, 64'h103, 1'b0, '0, 1'b1, 1'b0, 64'h40, 1'b1, hi(64'h38), 64'h38));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 64'h100, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 64'h100, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h100), 1'b1, 1'b1, 64'h104, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h104), 1'b1, 1'b1, 64'h108, 1'b1, hi(64'h100), 64'h100));
    tbl.push_back(mk(1'b1, 64'h200, 1'b1, hi(64'h108), 1'b1, 1'b0, 64'h10C, 1'b1, hi(64'h104), 64'h104));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 64'h200, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h200), 1'b1, 1'b1, 64'h204, 1'b0, '0, '0));
    tbl.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, hi(64'h204), 1'b1, 1'b0, 64'h208,
                     1'b1, hi(64'h200), 64'h200));
    tbl.push_back(mk(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 32'h1357_9BDF, 1'b1, 1'b1, 64'h0, 1'b0, '0, '0));
    tbl.push_back(mk(1'b0, '0, 1'b1, hi(64'h0), 1'b1, 1'b1, 64'h4, 1'b1, 32'h1357_9BDF,
                     64'hFFFF_FFFF_FFFF_FFFC));

    do_reset("dir");
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].valid, tbl[i].instr, tbl[i].ready);
      #1;
      chk($sformatf("dir[%0d] req", i),  AW'(bus.out_icache_req), AW'(tbl[i].exp_req));
      chk($sformatf("dir[%0d] addr", i), bus.out_icache_addr, tbl[i].exp_addr);
      chk($sformatf("dir[%0d] ov", i),   AW'(bus.out_instr_valid), AW'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        chk($sformatf("dir[%0d] instr", i), AW'(bus.out_instr), AW'(tbl[i].exp_instr));
        chk($sformatf("dir[%0d] pc", i),    bus.out_instr_pc, tbl[i].exp_pc);
      end
    end

    // ---- randomized traffic against the model ----
    do_reset("rnd");
    m_fpc = '0; m_pend = 0; m_disc = 0; m_pend_pc = '0; m_pend_instr = '0; m_lat = 0;
    m_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          redir, valid, ready, accept, push, pop, issue;
      logic [AW-1:0] rpc;
      logic [IW-1:0] instr;
      ent_t          e;

      @(negedge clk);
      rst_n = 1'b1;
      redir = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFF0 | AW'($urandom_range(0, 15));
      else
        rpc = {$urandom, $urandom};
      ready = ($urandom_range(0, 9) < 7);
      if (m_pend) begin
        valid = (m_lat == 0);
        instr = valid ? m_pend_instr : IW'($urandom);
      end else begin
        valid = ($urandom_range(0, 3) == 0);
        instr = IW'($urandom);
      end
      drive(redir, rpc, valid, instr, ready);

      accept = m_pend && valid;
      push   = accept && !m_disc && !redir;
      issue  = !redir && (!m_pend || accept) && ((m_q.size() + int'(push)) < DEPTH);
      pop    = (m_q.size() != 0) && ready && !redir;

      #1;
      chk($sformatf("rnd[%0d] req", cyc),  AW'(bus.out_icache_req), AW'(issue));
      chk($sformatf("rnd[%0d] addr", cyc), bus.out_icache_addr, m_fpc);
      chk($sformatf("rnd[%0d] ov", cyc),   AW'(bus.out_instr_valid), AW'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk($sformatf("rnd[%0d] instr", cyc), AW'(bus.out_instr), AW'(m_q[0].instr));
        chk($sformatf("rnd[%0d] pc", cyc),    bus.out_instr_pc, m_q[0].pc);
      end

      @(posedge clk);
      if (m_pend && !valid) m_lat--;
      if (redir) begin
        m_q.delete();
        m_fpc = {rpc[AW-1:2], 2'b00};
        if (accept) begin
          m_pend = 0;
          m_disc = 0;
        end else if (m_pend) begin
          m_disc = 1;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          e.instr = instr;
          e.pc    = m_pend_pc;
          m_q.push_back(e);
        end
        if (accept) begin
          m_pend = 0;
          m_disc = 0;
        end
        if (issue) begin
          m_pend       = 1;
          m_pend_pc    = m_fpc;
          m_fpc        = m_fpc + 64'd4;
          m_lat        = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
          m_pend_instr = IW'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
